// File: rtl/perf_counter_bank_if.sv
// Snapshot read port of perf_counter_bank.
//   master : requester, drives rd_req_i / rd_addr_i, receives the result
//   slave  : counter bank, returns rd_valid_o / rd_data_o / rd_ovf_o
//   rd_req_i   - read request, one result per request
//   rd_addr_i  - snapshot channel to read
//   rd_valid_o - result valid, one cycle after the request
//   rd_data_o  - snapshot counter value of the addressed channel
//   rd_ovf_o   - overflow flag captured with that snapshot
interface perf_counter_bank_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 32
);
  logic              rd_req_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              rd_valid_o;
  logic [CNT_W-1:0]  rd_data_o;
  logic              rd_ovf_o;

  modport master (
    output rd_req_i, rd_addr_i,
    input  rd_valid_o, rd_data_o, rd_ovf_o
  );

  modport slave (
    input  rd_req_i, rd_addr_i,
    output rd_valid_o, rd_data_o, rd_ovf_o
  );
endinterface

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with global enable, atomic snapshot/clear,
// wrap or saturate on overflow, sticky overflow flags with a maskable
// interrupt, and a registered single-port read of the snapshot bank.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   event_i       - per-channel one-cycle event strobes
//   enable_i      - global count enable
//   clear_i       - zero live counters and overflow flags
//   snapshot_i    - capture live counters/flags into the snapshot bank
//   ovf_mask_i    - per-channel interrupt enable
//   rd_bus        - snapshot read port (slave side)
//   ovf_o         - live sticky overflow flags
//   irq_o         - registered OR of masked overflow flags
module perf_counter_bank #(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned ADDR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         event_i,
  input  logic                      enable_i,
  input  logic                      clear_i,
  input  logic                      snapshot_i,
  input  logic [NUM_CH-1:0]         ovf_mask_i,
  perf_counter_bank_if.slave        rd_bus,
  output logic [NUM_CH-1:0]         ovf_o,
  output logic                      irq_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  cnt_q      [NUM_CH];
  logic [CNT_W-1:0]  cnt_d      [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0]  snap_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  snap_cnt_d [NUM_CH];
  logic [NUM_CH-1:0] snap_ovf_q, snap_ovf_d;
  logic              irq_q, irq_d;
  logic              rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;
  logic              rd_ovf_q, rd_ovf_d;

  // Live counters: clear wins over events and overflow.
  always_comb begin : live_next
    ovf_d = ovf_q;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      cnt_d[c] = cnt_q[c];
      if (clear_i) begin
        cnt_d[c] = '0;
        ovf_d[c] = 1'b0;
      end else if (enable_i && event_i[c]) begin
        if (cnt_q[c] == CNT_MAX) begin
          ovf_d[c] = 1'b1;
          cnt_d[c] = (SATURATE != 0) ? CNT_MAX : '0;
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  // Snapshot takes the pre-update live state, so snapshot+clear loses nothing.
  always_comb begin : snap_next
    snap_ovf_d = snapshot_i ? ovf_q : snap_ovf_q;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      snap_cnt_d[c] = snapshot_i ? cnt_q[c] : snap_cnt_q[c];
    end
  end

  // Read uses the pre-capture snapshot; out-of-range addresses return zero.
  always_comb begin : read_next
    rd_valid_d = rd_bus.rd_req_i;
    rd_data_d  = rd_data_q;
    rd_ovf_d   = rd_ovf_q;
    if (rd_bus.rd_req_i) begin
      if (32'(rd_bus.rd_addr_i) < NUM_CH) begin
        rd_data_d = snap_cnt_q[rd_bus.rd_addr_i];
        rd_ovf_d  = snap_ovf_q[rd_bus.rd_addr_i];
      end else begin
        rd_data_d = '0;
        rd_ovf_d  = 1'b0;
      end
    end
  end

  // Interrupt follows the registered flags, one cycle behind ovf_o.
  always_comb begin : irq_next
    irq_d = |(ovf_q & ovf_mask_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        cnt_q[c]      <= '0;
        snap_cnt_q[c] <= '0;
      end
      ovf_q      <= '0;
      snap_ovf_q <= '0;
      irq_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ovf_q   <= 1'b0;
    end else begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        cnt_q[c]      <= cnt_d[c];
        snap_cnt_q[c] <= snap_cnt_d[c];
      end
      ovf_q      <= ovf_d;
      snap_ovf_q <= snap_ovf_d;
      irq_q      <= irq_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_ovf_q   <= rd_ovf_d;
    end
  end

  assign ovf_o             = ovf_q;
  assign irq_o             = irq_q;
  assign rd_bus.rd_valid_o = rd_valid_q;
  assign rd_bus.rd_data_o  = rd_data_q;
  assign rd_bus.rd_ovf_o   = rd_ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a wrapping and a saturating instance share
// all stimulus; both are compared every cycle against an integer model.
module tb_perf_counter_bank;

  localparam int unsigned NCH  = 6;
  localparam int unsigned CW   = 8;
  localparam int unsigned AW   = 3;
  localparam int          MAXV = 255;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] event_i;
  logic           enable_i;
  logic           clear_i;
  logic           snapshot_i;
  logic [NCH-1:0] ovf_mask_i;
  logic           rd_req;
  logic [AW-1:0]  rd_addr;
  logic [NCH-1:0] ovf0, ovf1;
  logic           irq0, irq1;

  int n_checks = 0;
  int n_fail   = 0;

  perf_counter_bank_if #(.ADDR_W(AW), .CNT_W(CW)) rd0 ();
  perf_counter_bank_if #(.ADDR_W(AW), .CNT_W(CW)) rd1 ();

  assign rd0.rd_req_i  = rd_req;
  assign rd0.rd_addr_i = rd_addr;
  assign rd1.rd_req_i  = rd_req;
  assign rd1.rd_addr_i = rd_addr;

  perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .SATURATE(0), .ADDR_W(AW)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .event_i(event_i), .enable_i(enable_i),
    .clear_i(clear_i), .snapshot_i(snapshot_i), .ovf_mask_i(ovf_mask_i),
    .rd_bus(rd0.slave), .ovf_o(ovf0), .irq_o(irq0)
  );

  perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .SATURATE(1), .ADDR_W(AW)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .event_i(event_i), .enable_i(enable_i),
    .clear_i(clear_i), .snapshot_i(snapshot_i), .ovf_mask_i(ovf_mask_i),
    .rd_bus(rd1.slave), .ovf_o(ovf1), .irq_o(irq1)
  );

  always #5 clk = ~clk;

  // Reference model, index 0 = wrap, 1 = saturate.
  int m_cnt      [2][NCH];
  bit m_ovf      [2][NCH];
  int m_snap     [2][NCH];
  bit m_snap_ovf [2][NCH];
  bit m_rv   [2];
  int m_rdata[2];
  bit m_rovf [2];
  bit m_irq  [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < int'(NCH); c++) begin
        m_cnt[s][c] = 0; m_ovf[s][c] = 0; m_snap[s][c] = 0; m_snap_ovf[s][c] = 0;
      end
      m_rv[s] = 0; m_rdata[s] = 0; m_rovf[s] = 0; m_irq[s] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step(input int s);
    int a;
    a = int'(rd_addr);
    m_rv[s] = rd_req;
    if (rd_req) begin
      if (a < int'(NCH)) begin
        m_rdata[s] = m_snap[s][a];
        m_rovf[s]  = m_snap_ovf[s][a];
      end else begin
        m_rdata[s] = 0;
        m_rovf[s]  = 0;
      end
    end
    m_irq[s] = 0;
    for (int c = 0; c < int'(NCH); c++)
      if (m_ovf[s][c] && ovf_mask_i[c]) m_irq[s] = 1;
    if (snapshot_i) begin
      for (int c = 0; c < int'(NCH); c++) begin
        m_snap[s][c]     = m_cnt[s][c];
        m_snap_ovf[s][c] = m_ovf[s][c];
      end
    end
    for (int c = 0; c < int'(NCH); c++) begin
      if (clear_i) begin
        m_cnt[s][c] = 0;
        m_ovf[s][c] = 0;
      end else if (enable_i && event_i[c]) begin
        if (m_cnt[s][c] + 1 > MAXV) begin
          m_ovf[s][c] = 1;
          m_cnt[s][c] = (s == 1) ? MAXV : 0;
        end else begin
          m_cnt[s][c] = m_cnt[s][c] + 1;
        end
      end
    end
  endtask

  function automatic logic [NCH-1:0] exp_ovf(input int s);
    logic [NCH-1:0] v;
    for (int c = 0; c < int'(NCH); c++) v[c] = m_ovf[s][c];
    return v;
  endfunction

  task automatic check_all();
    chk("wrap_rd_valid", 64'(rd0.rd_valid_o), 64'(m_rv[0]));
    chk("wrap_rd_data",  64'(rd0.rd_data_o),  64'(m_rdata[0]));
    chk("wrap_rd_ovf",   64'(rd0.rd_ovf_o),   64'(m_rovf[0]));
    chk("wrap_ovf",      64'(ovf0),           64'(exp_ovf(0)));
    chk("wrap_irq",      64'(irq0),           64'(m_irq[0]));
    chk("sat_rd_valid",  64'(rd1.rd_valid_o), 64'(m_rv[1]));
    chk("sat_rd_data",   64'(rd1.rd_data_o),  64'(m_rdata[1]));
    chk("sat_rd_ovf",    64'(rd1.rd_ovf_o),   64'(m_rovf[1]));
    chk("sat_ovf",       64'(ovf1),           64'(exp_ovf(1)));
    chk("sat_irq",       64'(irq1),           64'(m_irq[1]));
  endtask

  // Inputs are applied while clk is low; outputs checked at the next negedge.
  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    event_i = '0; clear_i = 0; snapshot_i = 0; rd_req = 0; rd_addr = '0;
  endtask

  task automatic do_read(input int a);
    idle_inputs();
    rd_req = 1; rd_addr = AW'(a);
    tick();
    rd_req = 0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst_n = 0; enable_i = 0; ovf_mask_i = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    check_all();

    // 1: five events on channel 2, snapshot, read every channel
    enable_i = 1;
    event_i = NCH'(1 << 2);
    repeat (5) tick();
    idle_inputs(); snapshot_i = 1; tick();
    do_read(2);
    chk("t1_valid", 64'(rd0.rd_valid_o), 64'd1);
    chk("t1_data",  64'(rd0.rd_data_o),  64'd5);
    chk("t1_ovf",   64'(rd0.rd_ovf_o),   64'd0);
    for (int a = 0; a < int'(NCH); a++)
      if (a != 2) begin
        do_read(a);
        chk("t1_other", 64'(rd0.rd_data_o), 64'd0);
      end
    idle_inputs(); tick();

    // 2: disabled counting
    clear_i = 1; tick();
    idle_inputs(); enable_i = 0; event_i = '1;
    repeat (10) tick();
    idle_inputs(); snapshot_i = 1; tick();
    for (int a = 0; a < int'(NCH); a++) begin
      do_read(a);
      chk("t2_zero", 64'(rd1.rd_data_o), 64'd0);
    end

    // 3: 256 events on channel 0 overflow both variants
    enable_i = 1; ovf_mask_i = NCH'(1);
    idle_inputs(); event_i = NCH'(1);
    repeat (256) tick();
    chk("t3_ovf_wrap", 64'(ovf0[0]), 64'd1);
    chk("t3_ovf_sat",  64'(ovf1[0]), 64'd1);
    idle_inputs(); tick();
    chk("t3_irq_wrap", 64'(irq0), 64'd1);
    chk("t3_irq_sat",  64'(irq1), 64'd1);
    snapshot_i = 1; tick();
    do_read(0);
    chk("t3_cnt_wrap", 64'(rd0.rd_data_o), 64'd0);
    chk("t3_cnt_sat",  64'(rd1.rd_data_o), 64'd255);
    chk("t3_rdovf",    64'(rd1.rd_ovf_o),  64'd1);
    ovf_mask_i = '0; tick();
    chk("t3_irq_masked", 64'(irq0), 64'd0);

    // 4: atomic snapshot+clear with a same-cycle event
    idle_inputs(); clear_i = 1; tick();
    idle_inputs(); event_i = NCH'(1 << 3);
    repeat (7) tick();
    snapshot_i = 1; clear_i = 1; tick();
    idle_inputs();
    do_read(3);
    chk("t4_snap7", 64'(rd0.rd_data_o), 64'd7);
    snapshot_i = 1; tick();
    idle_inputs();
    do_read(3);
    chk("t4_live0", 64'(rd0.rd_data_o), 64'd0);

    // 5: out-of-range read, then back-to-back reads; snapshot+read same cycle
    do_read(NCH);
    chk("t5_oor_valid", 64'(rd0.rd_valid_o), 64'd1);
    chk("t5_oor_data",  64'(rd0.rd_data_o),  64'd0);
    event_i = NCH'(3); repeat (4) tick();
    idle_inputs(); event_i = NCH'(1); tick();
    idle_inputs(); snapshot_i = 1; tick();
    idle_inputs(); rd_req = 1; rd_addr = AW'(0); tick();
    chk("t5_b2b0", 64'(rd0.rd_data_o), 64'd5);
    rd_addr = AW'(1); tick();
    chk("t5_b2b1", 64'(rd0.rd_data_o), 64'd4);
    rd_addr = AW'(0); snapshot_i = 1; event_i = '1; tick();
    idle_inputs(); tick();

    // 6: asynchronous reset mid-count and mid-read
    event_i = '1; rd_req = 1; rd_addr = AW'(0); ovf_mask_i = '1;
    repeat (3) tick();
    #2 rst_n = 0;
    #1;
    chk("t6_rv",   64'(rd0.rd_valid_o), 64'd0);
    chk("t6_data", 64'(rd1.rd_data_o),  64'd0);
    chk("t6_ovf",  64'(ovf1),           64'd0);
    chk("t6_irq",  64'(irq1),           64'd0);
    model_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    tick();
    chk("t6_rv_after", 64'(rd0.rd_valid_o), 64'd0);

    // Random traffic
    ovf_mask_i = NCH'($urandom);
    for (int i = 0; i < 1500; i++) begin
      event_i    = NCH'($urandom);
      enable_i   = ($urandom_range(0, 9) != 0);
      clear_i    = ($urandom_range(0, 399) == 0);
      snapshot_i = ($urandom_range(0, 7) == 0);
      rd_req     = $urandom_range(0, 1) == 1;
      rd_addr    = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) ovf_mask_i = NCH'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised bank of NUM_CH independent event counters for pipeline, cache-stall and branch statistics. It succeeds the fixed six-counter performance counter and adds:
- global enable
- atomic snapshot and clear
- selectable wrap or saturate mode
- sticky per-channel overflow flags with a maskable interrupt
- a registered single-port read of the snapshot bank

It sits beside the core and samples one-cycle event strobes from the IF/ID/EX/MEM/WB stages and the I/D/L2 caches.

Parameters:
NUM_CH, 8, number of event channels (1..32)
CNT_W, 32, width of each counter in bits (8..64)
SATURATE, 0, 0 = counters wrap to 0 on overflow; 1 = counters hold at all-ones
ADDR_W, $clog2(NUM_CH) (minimum 1), width of the read address

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
event_i  input  NUM_CH  per-channel event strobe; each high cycle counts as one event
enable_i  input  1  global count enable; events are ignored while low
clear_i  input  1  zero all live counters and overflow flags
snapshot_i  input  1  copy all live counters into the snapshot bank
ovf_mask_i  input  NUM_CH  per-channel interrupt enable
rd_req_i  input  1  read request
rd_addr_i  input  ADDR_W  snapshot channel to read
rd_valid_o  output  1  rd_data_o/rd_ovf_o valid this cycle
rd_data_o  output  CNT_W  snapshot value of the addressed channel
rd_ovf_o  output  1  overflow flag captured with that snapshot
ovf_o  output  NUM_CH  live sticky overflow flags
irq_o  output  1  registered OR of (ovf_o AND ovf_mask_i)

Behaviour:
- Reset (rst_n low, asynchronous): all live counters, snapshot counters, snapshot overflow bits, ovf_o, irq_o, rd_valid_o, rd_data_o and rd_ovf_o go to 0.
- Live count, per channel per cycle:
  - If clear_i: counter becomes 0.
  - Else if enable_i and event_i[c]: counter becomes counter+1.
  - Otherwise: counter holds.
- Overflow, when an increment is attempted on an all-ones counter:
  - SATURATE=0: counter becomes 0 and ovf_o[c] is set.
  - SATURATE=1: counter stays all-ones and ovf_o[c] is set.
  - ovf_o[c] stays set until clear_i or reset.
- Clear priority: clear_i beats a same-cycle event and a same-cycle overflow. Flags and counters are 0 the next cycle.
- Snapshot:
  - On snapshot_i, the snapshot bank captures each live counter and ovf_o bit as they were at the start of the cycle, before that cycle's increment or clear.
  - snapshot_i and clear_i together therefore give an atomic read-and-clear, with no event lost or double-counted.
  - The snapshot bank holds its value until the next snapshot_i or reset. clear_i does not affect it.
- Read:
  - rd_req_i high in cycle N: rd_valid_o is high in cycle N+1, and rd_data_o/rd_ovf_o show the snapshot of channel rd_addr_i as sampled in cycle N.
  - Back-to-back requests are allowed, giving one result per cycle.
  - rd_addr_i >= NUM_CH returns 0 data and 0 ovf, with rd_valid_o still high.
  - When rd_valid_o is low, rd_data_o holds its last value.
  - If snapshot_i and rd_req_i are in the same cycle, the read returns the old (pre-capture) snapshot.
- Interrupt:
  - irq_o is registered: it goes high the cycle after a masked ovf_o bit is set.
  - It falls the cycle after clear_i or after the mask bit drops.
- Enable: enable_i low freezes counting only. Clear, snapshot and read remain functional.
- All events are single-cycle increments: a strobe held high for k enabled cycles counts k.

Test Plan:
1. Reset, then enable_i=1, event_i[2] high for 5 cycles, snapshot_i, read addr 2 -> rd_valid_o one cycle after the request, rd_data_o=5, rd_ovf_o=0; all other channels read 0.
2. enable_i=0 with event_i=all-ones for 10 cycles, then snapshot and read every channel -> all counters read 0.
3. CNT_W=8, SATURATE=0, 256 events on channel 0 with ovf_mask_i[0]=1 -> counter=0, ovf_o[0]=1, irq_o high one cycle later. Same stimulus with SATURATE=1 -> counter=255, ovf_o[0]=1.
4. Counter 3 holds 7, event_i[3] high in the same cycle as snapshot_i+clear_i:
   - reading snapshot ch3 returns 7.
   - the live counter is 0 the next cycle.
   - a later snapshot without further events reads 0.
5. rd_addr_i=NUM_CH with rd_req_i -> rd_valid_o=1, rd_data_o=0, rd_ovf_o=0. Back-to-back reads of ch0 then ch1 -> consecutive valid results in order.
6. Assert rst_n low mid-count and mid-read (rd_req_i high) -> all outputs 0 immediately, without waiting for a clock edge; rd_valid_o stays low after reset release until a new request.
